sort_stream_ctrl: RTL and testbench

Stream front/back end for the in-place memory sorter. Accepts a valid/ready word stream and writes it into the shared MM×MN sort memory. It then pulses the sorter's start with the word count and waits for done. Finally it streams the sorted contents back out on a valid/ready interface. It owns the memory port mux: the sorter drives memory only while a sort is in flight, and this block drives it at all other times.

---
 rtl/sort_stream_ctrl_if.sv | 58 +++++
 rtl/sort_stream_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sort_stream_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_stream_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : sort_stream_ctrl_if
// Function : Input/output word streams, sorter handshake and memory port bundle
//            for sort_stream_ctrl.
// Revision : 1.0
//==============================================================================
interface sort_stream_ctrl_if #(
    parameter int MN = 32,
    parameter int MW = 8
);
    logic          in_valid;
    logic [MN-1:0] in_data;
    logic          in_last;
    logic          in_ready;

    logic          out_valid;
    logic [MN-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    logic          sort_start;
    logic [MW:0]   sort_num;
    logic          sort_done;

    logic          srt_wr;
    logic          srt_rd;
    logic [MW-1:0] srt_wr_addr;
    logic [MW-1:0] srt_rd_addr;
    logic [MN-1:0] srt_wr_data;

    logic          mem_wr;
    logic          mem_rd;
    logic [MW-1:0] mem_wr_addr;
    logic [MW-1:0] mem_rd_addr;
    logic [MN-1:0] mem_wr_data;
    logic [MN-1:0] mem_rd_data;

    logic          busy;
    logic          ovf;

    // Controller side
    modport slave (
        input  in_valid, in_data, in_last, out_ready, sort_done,
        input  srt_wr, srt_rd, srt_wr_addr, srt_rd_addr, srt_wr_data, mem_rd_data,
        output in_ready, out_valid, out_data, out_last, sort_start, sort_num,
        output mem_wr, mem_rd, mem_wr_addr, mem_rd_addr, mem_wr_data, busy, ovf
    );

    // Environment side
    modport master (
        output in_valid, in_data, in_last, out_ready, sort_done,
        output srt_wr, srt_rd, srt_wr_addr, srt_rd_addr, srt_wr_data, mem_rd_data,
        input  in_ready, out_valid, out_data, out_last, sort_start, sort_num,
        input  mem_wr, mem_rd, mem_wr_addr, mem_rd_addr, mem_wr_data, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/sort_stream_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : sort_stream_ctrl
// Function : Loads a word stream into sort memory, kicks the sorter, then
//            streams the sorted words back out; owns the memory port mux.
// Revision : 1.0
//==============================================================================
module sort_stream_ctrl #(
    parameter int MM = 256,
    parameter int MN = 32,
    parameter int MW = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    sort_stream_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_KICK   = 2'd1,
        S_WAIT   = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    localparam logic [MW:0] C_LAST_IDX = (MW+1)'(MM - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [MW:0]   r_wcnt;
    logic [MW:0]   r_rcnt;
    logic [MW:0]   r_cnt;
    logic [MW:0]   r_ocnt;
    logic          r_ovf;
    logic          r_rd_pend;
    logic [MN-1:0] r_fifo [2];
    logic          r_wp;
    logic          r_rp;
    logic [1:0]    r_occ;

    logic          w_in_fire;
    logic          w_batch_end;
    logic          w_out_valid;
    logic          w_pop;
    logic          w_last_out;
    logic [2:0]    w_credit;
    logic          w_rd_issue;

    assign w_in_fire   = (r_state == S_LOAD) && bus.in_valid;
    assign w_batch_end = w_in_fire && (bus.in_last || (r_wcnt == C_LAST_IDX));
    assign w_out_valid = (r_occ != 2'd0);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_last_out  = w_out_valid && (r_ocnt == (r_cnt - 1'b1));
    // Words buffered plus the read in flight, after this cycle's pop.
    assign w_credit    = {1'b0, r_occ} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_rd_issue  = (r_state == S_UNLOAD) && (r_rcnt < r_cnt) && (w_credit < 3'd2);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.in_ready    = 1'b0;
        bus.sort_start  = 1'b0;
        bus.sort_num    = '0;
        bus.busy        = (r_state != S_LOAD);
        bus.ovf         = r_ovf;
        bus.out_valid   = w_out_valid;
        bus.out_data    = w_out_valid ? r_fifo[r_rp] : '0;
        bus.out_last    = w_last_out;
        bus.mem_wr      = w_in_fire;
        bus.mem_wr_addr = r_wcnt[MW-1:0];
        bus.mem_wr_data = bus.in_data;
        bus.mem_rd      = w_rd_issue;
        bus.mem_rd_addr = r_rcnt[MW-1:0];

        case (r_state)
            S_LOAD: begin
                bus.in_ready = 1'b1;
                if (w_batch_end) begin
                    // A lone word is already sorted, so skip the sorter.
                    w_state_nxt = (r_wcnt != '0) ? S_KICK : S_UNLOAD;
                end
            end
            S_KICK: begin
                bus.sort_start = 1'b1;
                bus.sort_num   = r_cnt;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                bus.sort_num = r_cnt;
                if (bus.sort_done) begin
                    w_state_nxt = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (w_pop && w_last_out) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase

        if ((r_state == S_KICK) || (r_state == S_WAIT)) begin
            bus.mem_wr      = bus.srt_wr;
            bus.mem_wr_addr = bus.srt_wr_addr;
            bus.mem_wr_data = bus.srt_wr_data;
            bus.mem_rd      = bus.srt_rd;
            bus.mem_rd_addr = bus.srt_rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wcnt    <= '0;
            r_rcnt    <= '0;
            r_cnt     <= '0;
            r_ocnt    <= '0;
            r_ovf     <= 1'b0;
            r_rd_pend <= 1'b0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_occ     <= 2'd0;
        end else begin
            r_ovf     <= w_in_fire && !bus.in_last && (r_wcnt == C_LAST_IDX);
            r_rd_pend <= w_rd_issue;
            r_occ     <= r_occ + {1'b0, r_rd_pend} - {1'b0, w_pop};
            if (w_in_fire) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_batch_end) begin
                r_cnt <= r_wcnt + 1'b1;
            end
            if (w_rd_issue) begin
                r_rcnt <= r_rcnt + 1'b1;
            end
            if (r_rd_pend) begin
                r_wp <= ~r_wp;
            end
            if (w_pop) begin
                r_rp   <= ~r_rp;
                r_ocnt <= r_ocnt + 1'b1;
            end
            if (w_pop && w_last_out) begin
                r_wcnt <= '0;
                r_rcnt <= '0;
                r_cnt  <= '0;
                r_ocnt <= '0;
            end
        end
    end

    // Read data lands one cycle after its strobe.
    always_ff @(posedge clk) begin
        if (r_rd_pend) begin
            r_fifo[r_wp] <= bus.mem_rd_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sort_stream_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_sort_stream_ctrl
// Function : Directed/randomised bench with memory, sorter and sorted-queue model.
// Revision : 1.0
//==============================================================================
module tb_sort_stream_ctrl;
    localparam int MM = 256;
    localparam int MN = 32;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   rst_cnt = 0;

    logic          s_wr = 1'b0;
    logic          s_done = 1'b0;
    logic          s_hold = 1'b0;
    logic [MW-1:0] s_addr = '0;
    logic [MN-1:0] s_data = '0;
    logic          inj_wr = 1'b0;
    logic          inj_rd = 1'b0;
    logic [MW-1:0] inj_addr = '0;
    logic [MN-1:0] inj_data = '0;

    logic [MN-1:0] mem [MM];
    logic [MN-1:0] rd_q;
    logic [MN-1:0] sent_q [$];

    sort_stream_ctrl_if #(.MN(MN), .MW(MW)) bus ();

    sort_stream_ctrl #(.MM(MM), .MN(MN), .MW(MW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.srt_wr      = s_wr | inj_wr;
    assign bus.srt_wr_addr = inj_wr ? inj_addr : s_addr;
    assign bus.srt_wr_data = inj_wr ? inj_data : s_data;
    assign bus.srt_rd      = inj_rd;
    assign bus.srt_rd_addr = inj_addr;
    assign bus.sort_done   = s_done;
    assign bus.mem_rd_data = rd_q;

    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        if (bus.mem_rd) rd_q <= mem[bus.mem_rd_addr];
        if (!reset_n) rst_cnt <= rst_cnt + 1;
    end

    // Sorter model: sorts the batch and writes it back through the mux.
    task automatic run_sorter();
        logic [MN-1:0] q [$];
        int n;
        int ep;
        n  = int'(bus.sort_num);
        ep = rst_cnt;
        for (int i = 0; i < n; i++) q.push_back(mem[i]);
        q.sort();
        @(posedge clk); #1;
        while (s_hold && ep == rst_cnt) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < n && ep == rst_cnt; i++) begin
            s_wr = 1'b1; s_addr = MW'(i); s_data = q[i];
            @(posedge clk); #1;
        end
        s_wr = 1'b0;
        if (ep == rst_cnt) begin
            s_done = 1'b1;
            @(posedge clk); #1;
            s_done = 1'b0;
        end
    endtask

    always begin
        @(posedge clk); #1;
        if (reset_n && bus.sort_start) run_sorter();
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_in_ready",   64'(bus.in_ready),   64'd1);
        chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
        chk("rst_out_last",   64'(bus.out_last),   64'd0);
        chk("rst_out_data",   64'(bus.out_data),   64'd0);
        chk("rst_sort_start", 64'(bus.sort_start), 64'd0);
        chk("rst_sort_num",   64'(bus.sort_num),   64'd0);
        chk("rst_mem_wr",     64'(bus.mem_wr),     64'd0);
        chk("rst_mem_rd",     64'(bus.mem_rd),     64'd0);
        chk("rst_busy",       64'(bus.busy),       64'd0);
        chk("rst_ovf",        64'(bus.ovf),        64'd0);
    endtask

    task automatic send_batch(input bit with_last);
        int n;
        n = sent_q.size();
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = sent_q[i];
            bus.in_last  = with_last && (i == n - 1);
            @(negedge clk);
            chk("load_in_ready", 64'(bus.in_ready),    64'd1);
            chk("load_mem_wr",   64'(bus.mem_wr),      64'd1);
            chk("load_wr_addr",  64'(bus.mem_wr_addr), 64'(i % MM));
            chk("load_wr_data",  64'(bus.mem_wr_data), 64'(sent_q[i]));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // mode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready
    task automatic recv_batch(input int mode, input bit chk_lat, input int exp_start, input int exp_ovf);
        logic [MN-1:0] exp_q [$];
        logic [MN-1:0] pd;
        logic          pl;
        bit  done, pv, pr;
        int  n, idx, cyc, t_done, t_first, starts, ovfs, ovf_cyc, rds, accs, max_out, rdy_hi, bubbles;
        n = (sent_q.size() > MM) ? MM : sent_q.size();
        for (int i = 0; i < n; i++) exp_q.push_back(sent_q[i]);
        exp_q.sort();
        done = 0; pv = 0; pr = 0; pd = '0; pl = 1'b0;
        idx = 0; cyc = 0; t_done = -100; t_first = -1; starts = 0; ovfs = 0; ovf_cyc = -1;
        rds = 0; accs = 0; max_out = 0; rdy_hi = 0; bubbles = 0;
        while (!done && cyc < 3000) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (bus.sort_start) begin
                starts++;
                chk("sort_num", 64'(bus.sort_num), 64'(n));
            end
            if (bus.ovf) begin ovfs++; ovf_cyc = cyc; end
            if (bus.sort_done) t_done = cyc;
            if (bus.in_ready) rdy_hi++;
            if (bus.mem_rd) rds++;
            if (pv && !pr) begin
                chk("stall_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_data",  64'(bus.out_data),  64'(pd));
                chk("stall_last",  64'(bus.out_last),  64'(pl));
            end
            if (bus.out_valid && t_first < 0) t_first = cyc;
            if (bus.out_valid && bus.out_ready) begin
                chk("out_data", 64'(bus.out_data), (idx < n) ? 64'(exp_q[idx]) : 64'hDEAD);
                chk("out_last", 64'(bus.out_last), 64'(idx == n - 1));
                idx++; accs++;
                if (bus.out_last || idx >= n) done = 1;
            end else if (mode == 0 && t_first >= 0) begin
                bubbles++;
            end
            if (rds - accs > max_out) max_out = rds - accs;
            pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pl = bus.out_last;
            cyc++;
            @(posedge clk); #1;
        end
        chk("unload_done",    64'(done),           64'd1);
        chk("word_count",     64'(idx),            64'(n));
        chk("start_pulses",   64'(starts),         64'(exp_start));
        chk("ovf_pulses",     64'(ovfs),           64'(exp_ovf));
        chk("in_ready_busy",  64'(rdy_hi),         64'd0);
        chk("fifo_depth_le2", 64'(max_out <= 2),   64'd1);
        if (exp_ovf != 0) chk("ovf_cycle", 64'(ovf_cyc), 64'd0);
        if (chk_lat) begin
            chk("done_to_valid", 64'(t_first - t_done), 64'd3);
            chk("bubbles",       64'(bubbles),          64'd0);
        end
    endtask

    initial begin
        logic [MN-1:0] w257;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Five-word batch, ready held high
        sent_q = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5};
        send_batch(1);
        recv_batch(0, 1, 1, 0);

        // Single word bypasses the sorter
        sent_q = '{32'd42};
        send_batch(1);
        recv_batch(0, 0, 0, 0);
        @(negedge clk);
        chk("single_in_ready", 64'(bus.in_ready), 64'd1);
        chk("single_busy",     64'(bus.busy),     64'd0);
        @(posedge clk); #1;

        // Truncated batch: word 257 waits for the next LOAD
        sent_q = {};
        for (int i = 0; i < MM; i++) sent_q.push_back(MN'($urandom_range(0, 999)));
        send_batch(0);
        w257 = 32'h1234_5678;
        bus.in_valid = 1'b1; bus.in_data = w257; bus.in_last = 1'b0;
        recv_batch(0, 1, 1, 1);
        @(negedge clk);
        chk("w257_in_ready", 64'(bus.in_ready),    64'd1);
        chk("w257_mem_wr",   64'(bus.mem_wr),      64'd1);
        chk("w257_addr",     64'(bus.mem_wr_addr), 64'd0);
        chk("w257_data",     64'(bus.mem_wr_data), 64'(w257));
        @(posedge clk); #1;
        bus.in_data = 32'h0000_0007; bus.in_last = 1'b1;
        @(negedge clk);
        chk("w258_addr", 64'(bus.mem_wr_addr), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        sent_q = '{w257, 32'h0000_0007};
        recv_batch(2, 0, 1, 0);

        // Batch of 8 under the 1,0,0,1 ready pattern
        sent_q = {};
        for (int i = 0; i < 8; i++) sent_q.push_back($urandom());
        send_batch(1);
        recv_batch(1, 0, 1, 0);

        // Sorter port pass-through while WAIT is held
        s_hold = 1'b1;
        sent_q = {};
        for (int i = 0; i < 6; i++) sent_q.push_back($urandom());
        send_batch(1);
        @(negedge clk);
        chk("kick_start", 64'(bus.sort_start), 64'd1);
        chk("kick_num",   64'(bus.sort_num),   64'd6);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = 32'h55;
        inj_wr = 1'b1; inj_rd = 1'b1; inj_addr = 8'd3; inj_data = 32'hAA;
        @(negedge clk);
        chk("wait_mem_wr",   64'(bus.mem_wr),      64'd1);
        chk("wait_wr_addr",  64'(bus.mem_wr_addr), 64'd3);
        chk("wait_wr_data",  64'(bus.mem_wr_data), 64'hAA);
        chk("wait_mem_rd",   64'(bus.mem_rd),      64'd1);
        chk("wait_rd_addr",  64'(bus.mem_rd_addr), 64'd3);
        chk("wait_in_ready", 64'(bus.in_ready),    64'd0);
        chk("wait_start",    64'(bus.sort_start),  64'd0);
        chk("wait_num",      64'(bus.sort_num),    64'd6);
        @(posedge clk); #1;
        inj_wr = 1'b0; inj_rd = 1'b0;
        @(negedge clk);
        chk("wait_no_write", 64'(bus.mem_wr),   64'd0);
        chk("wait_in_block", 64'(bus.in_ready), 64'd0);
        chk("wait_busy",     64'(bus.busy),     64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        s_hold = 1'b0;
        recv_batch(2, 0, 0, 0);

        // Reset during WAIT discards the batch
        s_hold = 1'b1;
        sent_q = {};
        for (int i = 0; i < 4; i++) sent_q.push_back($urandom());
        send_batch(1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        s_hold = 1'b0;
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        sent_q = {};
        for (int i = 0; i < 6; i++) sent_q.push_back($urandom());
        send_batch(1);
        recv_batch(2, 0, 1, 0);

        // Random batches against the sorted-queue model
        for (int b = 0; b < 4; b++) begin
            int n;
            n = $urandom_range(2, 24);
            sent_q = {};
            for (int i = 0; i < n; i++) sent_q.push_back(MN'($urandom_range(0, 63)));
            send_batch(1);
            recv_batch(int'($urandom_range(0, 2)), 0, 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
